clk_div_fanout: RTL and testbench

Multi-channel, parametrised clock-enable divider with a build-time bypass. It generates NUM_CH divided, 50 %-duty square waves from one clock. Each channel has its own enable and a runtime-programmable half-period, loaded over a valid/ready config port. The block sits between the core clock and downstream test/strobe consumers. With BYPASS set, every output is the raw clock.

---
 rtl/clk_div_fanout.sv | 132 +++++++++++++
 tb/tb_clk_div_fanout.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_fanout.sv
// rtl/clk_div_fanout.sv - multi-channel 50%-duty clock divider with shadowed half-period config
// Each channel runs IDLE/RUN/DRAIN; a new half-period is held in a shadow until the next period end.
module clk_div_fanout #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 8,
  parameter bit BYPASS = 1'b0,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] out
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [DIV_W-1:0] RST_DIV = (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

  if (BYPASS) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{rst, ch_en, cfg_valid, cfg_ch, cfg_div};
    assign out       = {NUM_CH{clk}};
    assign pending   = '0;
    assign cfg_ready = 1'b1;
  end else begin : g_div
    logic sel_hit;
    logic sel_pend;

    // Out-of-range channel indices never match, so they are always ready and silently dropped.
    always_comb begin
      sel_hit  = 1'b0;
      sel_pend = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ch == CH_W'(i)) begin
          sel_hit  = 1'b1;
          sel_pend = pending[i];
        end
      end
    end

    assign cfg_ready = sel_hit ? !sel_pend : 1'b1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_t           state;
      logic [DIV_W-1:0] cnt;
      logic [DIV_W-1:0] div;
      logic [DIV_W-1:0] div_sh;
      logic             pend_q;
      logic             out_q;
      logic             acc;
      logic             wrap;

      assign acc        = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));
      assign wrap       = (cnt == div - DIV_W'(1));
      assign pending[g] = pend_q;
      assign out[g]     = out_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state  <= IDLE;
          cnt    <= '0;
          div    <= RST_DIV;
          div_sh <= RST_DIV;
          pend_q <= 1'b0;
          out_q  <= 1'b0;
        end else begin
          // acc requires !pend_q, so it never coincides with an apply below.
          if (acc) begin
            div_sh <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            pend_q <= 1'b1;
          end
          case (state)
            IDLE: begin
              cnt   <= '0;
              out_q <= 1'b0;
              if (pend_q) begin
                div    <= div_sh;
                pend_q <= 1'b0;
              end
              if (ch_en[g]) begin
                out_q <= 1'b1;
                state <= RUN;
              end
            end
            RUN: begin
              if (!out_q && !ch_en[g]) begin
                cnt   <= '0;
                state <= IDLE;
              end else if (wrap) begin
                cnt   <= '0;
                out_q <= !out_q;
                if (out_q) begin
                  if (pend_q) begin
                    div    <= div_sh;
                    pend_q <= 1'b0;
                  end
                  if (!ch_en[g]) state <= IDLE;
                end
              end else begin
                cnt <= cnt + DIV_W'(1);
                if (!ch_en[g]) state <= DRAIN;
              end
            end
            DRAIN: begin
              // High phase always runs to completion; a returning enable just resumes RUN.
              if (wrap) begin
                cnt   <= '0;
                out_q <= 1'b0;
                if (pend_q) begin
                  div    <= div_sh;
                  pend_q <= 1'b0;
                end
                state <= ch_en[g] ? RUN : IDLE;
              end else begin
                cnt   <= cnt + DIV_W'(1);
                state <= ch_en[g] ? RUN : DRAIN;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_fanout.sv
// tb/tb_clk_div_fanout.sv - directed bench for clk_div_fanout (4-ch, 3-ch and bypass builds)
module tb_clk_div_fanout;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] en4 = '0, pend4, out4;
  logic       cv4 = 1'b0, rdy4;
  logic [1:0] cc4 = '0;
  logic [7:0] cd4 = '0;

  logic [2:0] en3 = '0, pend3, out3;
  logic       cv3 = 1'b0, rdy3;
  logic [1:0] cc3 = '0;
  logic [7:0] cd3 = '0;

  logic [3:0] enb = '0, pendb, outb;
  logic       cvb = 1'b0, rdyb;
  logic [1:0] ccb = '0;
  logic [7:0] cdb = '0;

  int checks = 0;
  int failures = 0;

  clk_div_fanout u_dut4 (
    .clk(clk), .rst(rst), .ch_en(en4), .cfg_valid(cv4), .cfg_ch(cc4), .cfg_div(cd4),
    .cfg_ready(rdy4), .pending(pend4), .out(out4)
  );

  clk_div_fanout #(.NUM_CH(3)) u_dut3 (
    .clk(clk), .rst(rst), .ch_en(en3), .cfg_valid(cv3), .cfg_ch(cc3), .cfg_div(cd3),
    .cfg_ready(rdy3), .pending(pend3), .out(out3)
  );

  clk_div_fanout #(.BYPASS(1'b1)) u_dutb (
    .clk(clk), .rst(rst), .ch_en(enb), .cfg_valid(cvb), .cfg_ch(ccb), .cfg_div(cdb),
    .cfg_ready(rdyb), .pending(pendb), .out(outb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic en_c[16]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic exp_c[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                      1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [2:0] e3;
    // reset held three cycles
    tick();
    check_eq("rst_out4", 32'(out4), 32'h0);
    check_eq("rst_pend4", 32'(pend4), 32'h0);
    check_eq("rst_rdy4", 32'(rdy4), 32'h1);
    check_eq("rst_rdyb", 32'(rdyb), 32'h1);
    check_eq("rst_pendb", 32'(pendb), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    en4 = 4'b0001;

    // default div=2: period 4, 1-cycle enable latency
    tick();
    check_eq("en_out4", 32'(out4), 32'h1);
    check_eq("en_pend4", 32'(pend4), 32'h0);
    check_eq("en_rdy4", 32'(rdy4), 32'h1);
    for (int k = 1; k < 8; k++) begin
      tick();
      check_eq($sformatf("def_per_k%0d", k), 32'(out4[0]), 32'(((k / 2) % 2) == 0));
    end

    // live reprogram mid-high phase
    tick();
    check_eq("lr_hi", 32'(out4[0]), 32'h1);
    cv4 = 1'b1; cc4 = 2'd0; cd4 = 8'd5;
    #1 check_eq("lr_rdy1", 32'(rdy4), 32'h1);
    tick();
    check_eq("lr_pend", 32'(pend4), 32'h1);
    check_eq("lr_still_hi", 32'(out4[0]), 32'h1);
    cd4 = 8'd7;
    #1 check_eq("lr_rdy_busy", 32'(rdy4), 32'h0);
    tick();
    cv4 = 1'b0;
    check_eq("lr_applied", 32'(pend4), 32'h0);
    for (int k = 0; k <= 10; k++) begin
      check_eq($sformatf("lr_per_k%0d", k), 32'(out4[0]), 32'(k >= 5 && k < 10));
      tick();
    end

    // idle load of zero on ch1 becomes div=1
    cv4 = 1'b1; cc4 = 2'd1; cd4 = 8'd0;
    #1 check_eq("z_rdy", 32'(rdy4), 32'h1);
    tick();
    cv4 = 1'b0;
    check_eq("z_pend", 32'(pend4[1]), 32'h1);
    tick();
    check_eq("z_apply", 32'(pend4[1]), 32'h0);
    en4[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq($sformatf("z_per_k%0d", k), 32'(out4[1]), 32'((k % 2) == 0));
    end

    // ch2 div=4: disable mid-high drains, re-enable during drain keeps the edge train
    cv4 = 1'b1; cc4 = 2'd2; cd4 = 8'd4;
    tick();
    cv4 = 1'b0;
    tick();
    check_eq("d_pend", 32'(pend4[2]), 32'h0);
    for (int k = 0; k < 16; k++) begin
      en4[2] = en_c[k];
      tick();
      check_eq($sformatf("drain_k%0d", k), 32'(out4[2]), 32'(exp_c[k]));
    end

    // 3-channel build: out-of-range accept, then div 1/2/3 concurrently
    cv3 = 1'b1; cc3 = 2'd3; cd3 = 8'd9;
    #1 check_eq("oor_rdy", 32'(rdy3), 32'h1);
    tick();
    cv3 = 1'b0;
    check_eq("oor_pend", 32'(pend3), 32'h0);
    check_eq("oor_out", 32'(out3), 32'h0);
    cv3 = 1'b1; cc3 = 2'd0; cd3 = 8'd1;
    tick();
    cc3 = 2'd2; cd3 = 8'd3;
    tick();
    cv3 = 1'b0;
    check_eq("c3_pend_mix", 32'(pend3), 32'h4);
    tick();
    check_eq("c3_pend_clr", 32'(pend3), 32'h0);
    en3 = 3'b111;
    for (int k = 0; k < 12; k++) begin
      tick();
      e3[0] = ((k / 1) % 2) == 0;
      e3[1] = ((k / 2) % 2) == 0;
      e3[2] = ((k / 3) % 2) == 0;
      check_eq($sformatf("c3_k%0d", k), 32'(out3), 32'(e3));
    end

    // bypass build follows clk and ignores everything else
    cvb = 1'b1; enb = 4'hf;
    for (int k = 0; k < 3; k++) begin
      ccb = 2'(k); cdb = 8'(k + 3);
      tick();
      check_eq($sformatf("byp_hi_k%0d", k), 32'(outb), 32'hf);
      check_eq($sformatf("byp_rdy_k%0d", k), 32'(rdyb), 32'h1);
      check_eq($sformatf("byp_pend_k%0d", k), 32'(pendb), 32'h0);
      @(negedge clk);
      #1 check_eq($sformatf("byp_lo_k%0d", k), 32'(outb), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
